window_serializer: RTL

//  Inverse of the sliding-window generator. Accepts one full parallel window of WINDOW_SIZE samples

---
 rtl/window_serializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/window_serializer.sv
// window_serializer: captures one parallel window and replays it oldest-first, one sample per beat.
// Optional macro WINDOW_SER_BACK2BACK_EN allows a new window to load on the final beat (no idle bubble).
module window_serializer #(
  parameter int DATA_W      = 16,
  parameter int WINDOW_SIZE = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           win_valid,
  output logic                           win_ready,
  input  logic [DATA_W-1:0]              window [WINDOW_SIZE],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_sample,
  output logic [$clog2(WINDOW_SIZE)-1:0] out_index,
  output logic                           out_last
);

  localparam int IDX_W = $clog2(WINDOW_SIZE);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [IDX_W-1:0]  IDX_ZERO    = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(WINDOW_SIZE - 1);
  localparam logic [DATA_W-1:0] SAMPLE_ZERO = {DATA_W{1'b0}};

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] buf_q [WINDOW_SIZE];

  logic              win_ready_s;
  logic              load_s;
  logic              beat_s;
  logic [IDX_W-1:0]  idx_inc_s;

  // Capture acceptance: in back-to-back mode the final beat doubles as a load slot.
`ifdef WINDOW_SER_BACK2BACK_EN
  assign win_ready_s = (state_q == ST_IDLE) ||
                       ((state_q == ST_SEND) && last_q && out_ready);
`else
  assign win_ready_s = (state_q == ST_IDLE);
`endif

  assign load_s    = win_valid && win_ready_s;
  assign beat_s    = valid_q && out_ready;
  assign idx_inc_s = idx_q + IDX_ONE;

  // Next-state logic: the output sample is preloaded so out_sample never depends on inputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    last_d   = last_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          state_d  = ST_SEND;
          idx_d    = IDX_ZERO;
          sample_d = window[0];
          last_d   = 1'b0;
          valid_d  = 1'b1;
        end else begin
          valid_d  = 1'b0;
          last_d   = 1'b0;
        end
      end
      ST_SEND: begin
        if (!beat_s) begin
          valid_d  = 1'b1;
        end else if (idx_q != IDX_LAST) begin
          idx_d    = idx_inc_s;
          sample_d = buf_q[idx_inc_s];
          last_d   = (idx_inc_s == IDX_LAST);
        end else if (load_s) begin
          idx_d    = IDX_ZERO;
          sample_d = window[0];
          last_d   = 1'b0;
        end else begin
          state_d  = ST_IDLE;
          idx_d    = IDX_ZERO;
          last_d   = 1'b0;
          valid_d  = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        idx_d    = IDX_ZERO;
        last_d   = 1'b0;
        valid_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_ZERO;
      sample_q <= SAMPLE_ZERO;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end

  // Window storage has no reset; its contents are meaningless until the first capture.
  always_ff @(posedge clk) begin
    if (load_s) begin
      buf_q <= window;
    end
  end

  assign win_ready  = win_ready_s && !rst;
  assign out_valid  = valid_q;
  assign out_sample = sample_q;
  assign out_index  = idx_q;
  assign out_last   = last_q;

endmodule
